// File: rtl/tensor_core_matmul_sequencer_pkg.sv
// Shared tensor-core types: matrix geometry, element/matrix typedefs, sequencer FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tensor_core_pkg;

  localparam int MATRIX_DIM   = 4;
  localparam int NUM_MATRICES = 2;
  localparam int ELEM_WIDTH   = 4;

  typedef logic signed [ELEM_WIDTH-1:0] elem_t;
  typedef elem_t matrix_t [MATRIX_DIM][MATRIX_DIM];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    WRITE   = 2'd2
  } matmul_state_t;

  // Accumulator holds four full-width products plus two bits of sum growth.
  function automatic int acc_width(input int data_width);
    return 2 * data_width + 2;
  endfunction

endpackage

// File: rtl/tensor_core_matmul_sequencer_if.sv
// Bulk read/write bus and start/busy/done handshake between controller and matmul sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the sequencer is idle.
interface tensor_core_matmul_sequencer_if #(
  parameter int DATA_WIDTH = 4
);

  logic                         start_in;
  logic signed [DATA_WIDTH-1:0] bulk_read_data_in
    [tensor_core_pkg::NUM_MATRICES][tensor_core_pkg::MATRIX_DIM][tensor_core_pkg::MATRIX_DIM];
  logic                         busy_out;
  logic                         done_out;
  logic                         bulk_write_enable_out;
  logic signed [DATA_WIDTH-1:0] bulk_write_data_out
    [tensor_core_pkg::NUM_MATRICES][tensor_core_pkg::MATRIX_DIM][tensor_core_pkg::MATRIX_DIM];

  modport slave (
    input  start_in,
    input  bulk_read_data_in,
    output busy_out,
    output done_out,
    output bulk_write_enable_out,
    output bulk_write_data_out
  );

  modport master (
    output start_in,
    output bulk_read_data_in,
    input  busy_out,
    input  done_out,
    input  bulk_write_enable_out,
    input  bulk_write_data_out
  );

endinterface

// File: rtl/tensor_core_dot4.sv
// Four-term signed dot product followed by a saturate or wrap narrowing stage.
// Latency: combinational.
// Backpressure: none.
module tensor_core_dot4
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter bit SATURATE   = 1'b1
) (
  input  logic signed [DATA_WIDTH-1:0] a_row [MATRIX_DIM],
  input  logic signed [DATA_WIDTH-1:0] b_col [MATRIX_DIM],
  output logic signed [DATA_WIDTH-1:0] result
);

  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int MAX_INT    = (2 ** (DATA_WIDTH - 1)) - 1;
  localparam int MIN_INT    = -(2 ** (DATA_WIDTH - 1));
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(MAX_INT);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(MIN_INT);

  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [PROD_WIDTH-1:0] prod;

  // Sum the four full-precision products in the widened accumulator.
  always_comb begin
    acc  = '0;
    prod = '0;
    for (int k = 0; k < MATRIX_DIM; k++) begin
      prod = PROD_WIDTH'(a_row[k]) * PROD_WIDTH'(b_col[k]);
      acc  = acc + ACC_WIDTH'(prod);
    end
  end

  // Narrow to element width: clamp to the signed range, or keep the low bits.
  always_comb begin
    result = acc[DATA_WIDTH-1:0];
    if (SATURATE) begin
      if (acc > ACC_MAX) begin
        result = ACC_MAX[DATA_WIDTH-1:0];
      end else if (acc < ACC_MIN) begin
        result = ACC_MIN[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/tensor_core_matmul_sequencer.sv
// Snapshots A/B from the register file, computes C = A x B one element per cycle, writes {C, B} back.
// Latency: 17 edges from accepted start to the edge that captures the write; done pulses one cycle.
// Backpressure: start is ignored while busy; no request queuing.
module tensor_core_matmul_sequencer
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter bit SATURATE   = 1'b1
) (
  input logic clock_in,
  input logic reset_n_in,
  tensor_core_matmul_sequencer_if.slave bus
);

  localparam int IDX_WIDTH = $clog2(MATRIX_DIM * MATRIX_DIM);
  localparam int RC_WIDTH  = $clog2(MATRIX_DIM);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(MATRIX_DIM * MATRIX_DIM - 1);

  matmul_state_t        state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 capture_en;
  logic                 compute_en;

  logic signed [DATA_WIDTH-1:0] snap_a [MATRIX_DIM][MATRIX_DIM];
  logic signed [DATA_WIDTH-1:0] snap_b [MATRIX_DIM][MATRIX_DIM];
  logic signed [DATA_WIDTH-1:0] c_q    [MATRIX_DIM][MATRIX_DIM];

  logic [RC_WIDTH-1:0]          row;
  logic [RC_WIDTH-1:0]          col;
  logic signed [DATA_WIDTH-1:0] a_row [MATRIX_DIM];
  logic signed [DATA_WIDTH-1:0] b_col [MATRIX_DIM];
  logic signed [DATA_WIDTH-1:0] dot_result;

  assign row = idx_q[IDX_WIDTH-1 -: RC_WIDTH];
  assign col = idx_q[RC_WIDTH-1:0];

  // FSM state and element index registers.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic plus snapshot/compute enables.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    capture_en = 1'b0;
    compute_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          state_d    = COMPUTE;
          idx_d      = '0;
          capture_en = 1'b1;
        end
      end
      COMPUTE: begin
        compute_en = 1'b1;
        idx_d      = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Private A/B snapshot taken only at the start edge; C filled one element per compute edge.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < MATRIX_DIM; i++) begin
        for (int j = 0; j < MATRIX_DIM; j++) begin
          snap_a[i][j] <= '0;
          snap_b[i][j] <= '0;
          c_q[i][j]    <= '0;
        end
      end
    end else begin
      if (capture_en) begin
        for (int i = 0; i < MATRIX_DIM; i++) begin
          for (int j = 0; j < MATRIX_DIM; j++) begin
            snap_a[i][j] <= bus.bulk_read_data_in[0][i][j];
            snap_b[i][j] <= bus.bulk_read_data_in[1][i][j];
          end
        end
      end
      if (compute_en) begin
        c_q[row][col] <= dot_result;
      end
    end
  end

  // Present row idx/4 of A and column idx%4 of B to the dot-product unit.
  always_comb begin
    for (int k = 0; k < MATRIX_DIM; k++) begin
      a_row[k] = snap_a[row][k];
      b_col[k] = snap_b[k][col];
    end
  end

  tensor_core_dot4 #(
    .DATA_WIDTH (DATA_WIDTH),
    .SATURATE   (SATURATE)
  ) u_dot4 (
    .a_row  (a_row),
    .b_col  (b_col),
    .result (dot_result)
  );

  assign bus.busy_out              = (state_q != IDLE);
  assign bus.done_out              = (state_q == WRITE);
  assign bus.bulk_write_enable_out = (state_q == WRITE);

  // Write bus is driven straight from registers: slot 0 = C, slot 1 = B snapshot.
  always_comb begin
    for (int i = 0; i < MATRIX_DIM; i++) begin
      for (int j = 0; j < MATRIX_DIM; j++) begin
        bus.bulk_write_data_out[0][i][j] = c_q[i][j];
        bus.bulk_write_data_out[1][i][j] = snap_b[i][j];
      end
    end
  end

endmodule

// File: tb/tb_tensor_core_matmul_sequencer.sv
// Bench: saturating and wrapping sequencers run side by side against a behavioural register file.
// Expected writebacks are queued when a start is driven and compared when the strobe appears.
// All comparisons go through chk; one summary line at the end.
module tb_tensor_core_matmul_sequencer;

  typedef logic signed [3:0] el_t;
  typedef el_t mat_t [4][4];
  typedef struct {
    int          cyc;
    logic [63:0] c;
    logic [63:0] b;
  } exp_t;

  logic clock_in = 1'b0;
  logic reset_n_in;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_push = 0;
  int   n_str_s = 0, n_str_w = 0, n_done_s = 0, n_done_w = 0;
  exp_t q_s[$];
  exp_t q_w[$];

  logic        ld_req = 1'b0;
  mat_t        ld_a, ld_b;
  logic [63:0] obs_c_s, obs_b_s, obs_c_w, obs_b_w;

  always #5 clock_in = ~clock_in;

  tensor_core_matmul_sequencer_if #(.DATA_WIDTH(4)) if_s ();
  tensor_core_matmul_sequencer_if #(.DATA_WIDTH(4)) if_w ();

  tensor_core_matmul_sequencer #(.DATA_WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .bus        (if_s)
  );

  tensor_core_matmul_sequencer #(.DATA_WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .bus        (if_w)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mat_t mm(input mat_t a, input mat_t b, input bit sat);
    mat_t r;
    int   s;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(a[i][k]) * int'(b[k][j]);
        if (sat) s = (s > 7) ? 7 : ((s < -8) ? -8 : s);
        r[i][j] = el_t'(s);
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] flat(input mat_t m);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) f[(i*4+j)*4 +: 4] = m[i][j];
    return f;
  endfunction

  // Cycle counter: value after edge N is N.
  always @(posedge clock_in) cyc <= cyc + 1;

  // Behavioural register file per DUT: bench loads win, otherwise capture the bulk write.
  always @(posedge clock_in) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (ld_req) begin
          if_s.bulk_read_data_in[0][i][j] <= ld_a[i][j];
          if_s.bulk_read_data_in[1][i][j] <= ld_b[i][j];
          if_w.bulk_read_data_in[0][i][j] <= ld_a[i][j];
          if_w.bulk_read_data_in[1][i][j] <= ld_b[i][j];
        end else begin
          if (if_s.bulk_write_enable_out) begin
            if_s.bulk_read_data_in[0][i][j] <= if_s.bulk_write_data_out[0][i][j];
            if_s.bulk_read_data_in[1][i][j] <= if_s.bulk_write_data_out[1][i][j];
          end
          if (if_w.bulk_write_enable_out) begin
            if_w.bulk_read_data_in[0][i][j] <= if_w.bulk_write_data_out[0][i][j];
            if_w.bulk_read_data_in[1][i][j] <= if_w.bulk_write_data_out[1][i][j];
          end
        end
      end
    end
  end

  // Flatten both write buses for comparison.
  always_comb begin
    obs_c_s = '0; obs_b_s = '0; obs_c_w = '0; obs_b_w = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        obs_c_s[(i*4+j)*4 +: 4] = if_s.bulk_write_data_out[0][i][j];
        obs_b_s[(i*4+j)*4 +: 4] = if_s.bulk_write_data_out[1][i][j];
        obs_c_w[(i*4+j)*4 +: 4] = if_w.bulk_write_data_out[0][i][j];
        obs_b_w[(i*4+j)*4 +: 4] = if_w.bulk_write_data_out[1][i][j];
      end
    end
  end

  // Scoreboard: each strobe pops one expectation and checks timing, done and both slots.
  always @(negedge clock_in) begin
    exp_t e;
    if (if_s.done_out) n_done_s++;
    if (if_w.done_out) n_done_w++;
    if (if_s.bulk_write_enable_out) begin
      n_str_s++;
      if (q_s.size() == 0) chk("sat_unexpected_strobe", 64'd1, 64'd0);
      else begin
        e = q_s.pop_front();
        chk("sat_strobe_cycle", 64'(cyc), 64'(e.cyc));
        chk("sat_done", 64'(if_s.done_out), 64'd1);
        chk("sat_slot0_c", obs_c_s, e.c);
        chk("sat_slot1_b", obs_b_s, e.b);
      end
    end
    if (if_w.bulk_write_enable_out) begin
      n_str_w++;
      if (q_w.size() == 0) chk("wrap_unexpected_strobe", 64'd1, 64'd0);
      else begin
        e = q_w.pop_front();
        chk("wrap_strobe_cycle", 64'(cyc), 64'(e.cyc));
        chk("wrap_done", 64'(if_w.done_out), 64'd1);
        chk("wrap_slot0_c", obs_c_w, e.c);
        chk("wrap_slot1_b", obs_b_w, e.b);
      end
    end
  end

  task automatic set_start(input logic v);
    if_s.start_in = v;
    if_w.start_in = v;
  endtask

  task automatic load(input mat_t a, input mat_t b);
    ld_a = a;
    ld_b = b;
    ld_req = 1'b1;
    @(posedge clock_in);
    @(negedge clock_in);
    ld_req = 1'b0;
  endtask

  task automatic push(input mat_t a, input mat_t b, input int at_cyc);
    q_s.push_back('{at_cyc, flat(mm(a, b, 1'b1)), flat(b)});
    q_w.push_back('{at_cyc, flat(mm(a, b, 1'b0)), flat(b)});
    n_push++;
  endtask

  // Called at a negedge while idle; returns at the negedge after the accepting edge.
  task automatic go(input mat_t a, input mat_t b, input bit expect_write);
    if (expect_write) push(a, b, cyc + 17);
    set_start(1'b1);
    @(posedge clock_in);
    @(negedge clock_in);
    set_start(1'b0);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 60; n++) begin
      @(negedge clock_in);
      if (!if_s.busy_out && !if_w.busy_out) return;
    end
    chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic fill(output mat_t m, input int v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m[i][j] = el_t'(v);
  endtask

  initial begin
    mat_t a, b, a2, b2, c1s, c1w;
    int   str_before;

    reset_n_in = 1'b1;
    set_start(1'b0);
    #2 reset_n_in = 1'b0;
    repeat (3) @(negedge clock_in);
    chk("rst_busy", 64'({if_s.busy_out, if_w.busy_out}), 64'd0);
    chk("rst_done", 64'({if_s.done_out, if_w.done_out}), 64'd0);
    chk("rst_we", 64'({if_s.bulk_write_enable_out, if_w.bulk_write_enable_out}), 64'd0);
    chk("rst_wdata", obs_c_s | obs_b_s | obs_c_w | obs_b_w, 64'd0);
    reset_n_in = 1'b1;
    @(negedge clock_in);

    // Identity times B(i-j): C equals B.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j] = (i == j) ? el_t'(1) : el_t'(0);
        b[i][j] = el_t'(i - j);
      end
    load(a, b);
    go(a, b, 1'b1);
    chk("busy_after_start", 64'({if_s.busy_out, if_w.busy_out}), 64'd3);
    wait_idle();

    // All 7: raw 196 saturates to 7, wraps to 4.
    fill(a, 7); fill(b, 7);
    load(a, b);
    go(a, b, 1'b1);
    wait_idle();

    // A all -8, B all 7: raw -224 saturates to -8, wraps to 0.
    fill(a, -8); fill(b, 7);
    load(a, b);
    go(a, b, 1'b1);
    wait_idle();

    // Random operands; start pulsed at E5 and in WRITE, register file changed mid-compute.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j]  = el_t'($urandom_range(0, 15));
        b[i][j]  = el_t'($urandom_range(0, 15));
        a2[i][j] = el_t'($urandom_range(0, 15));
        b2[i][j] = el_t'($urandom_range(0, 15));
      end
    load(a, b);
    go(a, b, 1'b1);
    repeat (4) @(negedge clock_in);
    set_start(1'b1);
    @(posedge clock_in);
    @(negedge clock_in);
    set_start(1'b0);
    load(a2, b2);
    repeat (10) @(negedge clock_in);
    chk("write_phase_we", 64'(if_s.bulk_write_enable_out), 64'd1);
    set_start(1'b1);
    @(posedge clock_in);
    @(negedge clock_in);
    set_start(1'b0);
    chk("idle_after_write", 64'({if_s.busy_out, if_w.busy_out}), 64'd0);
    repeat (3) @(negedge clock_in);
    chk("start_in_write_ignored", 64'({if_s.busy_out, if_w.busy_out}), 64'd0);

    // Start held high: accepts at E0 and E18; second run sees the written-back C.
    fill(a, 0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j] = el_t'($urandom_range(0, 15));
        b[i][j] = el_t'($urandom_range(0, 15));
      end
    load(a, b);
    c1s = mm(a, b, 1'b1);
    c1w = mm(a, b, 1'b0);
    q_s.push_back('{cyc + 17, flat(c1s), flat(b)});
    q_w.push_back('{cyc + 17, flat(c1w), flat(b)});
    q_s.push_back('{cyc + 35, flat(mm(c1s, b, 1'b1)), flat(b)});
    q_w.push_back('{cyc + 35, flat(mm(c1w, b, 1'b0)), flat(b)});
    n_push += 2;
    set_start(1'b1);
    repeat (18) @(posedge clock_in);
    @(negedge clock_in);
    chk("held_gap_busy", 64'({if_s.busy_out, if_w.busy_out}), 64'd0);
    @(posedge clock_in);
    @(negedge clock_in);
    set_start(1'b0);
    chk("held_second_accept", 64'({if_s.busy_out, if_w.busy_out}), 64'd3);
    wait_idle();

    // Asynchronous reset at idx 7 aborts with no strobe.
    fill(b, 5);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) a[i][j] = el_t'($urandom_range(0, 15));
    load(a, b);
    go(a, b, 1'b0);
    repeat (7) @(negedge clock_in);
    chk("pre_abort_slot1", obs_b_s, flat(b));
    str_before = n_str_s + n_str_w;
    #2 reset_n_in = 1'b0;
    #1;
    chk("abort_busy", 64'({if_s.busy_out, if_w.busy_out}), 64'd0);
    chk("abort_we", 64'({if_s.bulk_write_enable_out, if_w.bulk_write_enable_out}), 64'd0);
    chk("abort_wdata", obs_c_s | obs_b_s | obs_c_w | obs_b_w, 64'd0);
    repeat (2) @(negedge clock_in);
    reset_n_in = 1'b1;
    repeat (25) @(negedge clock_in);
    chk("abort_no_strobe", 64'(n_str_s + n_str_w), 64'(str_before));

    // Normal run after the abort.
    load(a, b);
    go(a, b, 1'b1);
    wait_idle();
    repeat (3) @(negedge clock_in);

    chk("queue_drained", 64'(q_s.size() + q_w.size()), 64'd0);
    chk("sat_strobe_count", 64'(n_str_s), 64'(n_push));
    chk("wrap_strobe_count", 64'(n_str_w), 64'(n_push));
    chk("sat_done_count", 64'(n_done_s), 64'(n_push));
    chk("wrap_done_count", 64'(n_done_w), 64'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
